flags_unit: RTL
===============

# flags_unit

Architectural flag register for the pipelined core: holds the 5-bit flag word {saturated, N, Z, C, V} that the condition-evaluation logic reads, and commits the flag updates produced in Execute. Tracks in-flight flag-setting instructions between Decode and Execute and raises a stall when a conditional instruction in Decode would read stale flags. Optionally provides a shadow stack for flag save/restore on exception entry/return.

## Interface
- `ALU_FLAGS_WIDTH`, 5, flag word width; bit order {saturated, N, Z, C, V} = [4:0]
- `PIPE_DEPTH`, 3, maximum in-flight flag writers between Decode issue and Execute commit
- `STACK_DEPTH`, 4, shadow stack entries (only with `FLAGS_SHADOW_STACK_EN`)

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `ex_valid`  in  1  Execute-stage instruction valid
- `ex_flags_write`  in  2  [1] writes N,Z; [0] writes C,V and sticky saturated
- `ex_cond_ex`  in  1  Execute instruction's condition passed
- `ex_alu_flags`  in  5  ALU-generated flags, same bit order
- `dec_issue`  in  1  Decode instruction leaves Decode this cycle
- `dec_sets_flags`  in  1  issuing instruction has nonzero FlagsWrite
- `dec_reads_flags`  in  1  instruction in Decode has Cond != AL (1110)
- `flush`  in  1  pipeline flush; discards in-flight writers
- `sat_clear`  in  1  clears sticky saturated bit
- `save_req`  in  1  push current flags (stack builds only)
- `restore_req`  in  1  pop into flag register (stack builds only)
- `flags`  out  5  registered architectural flags
- `flags_hazard`  out  1  combinational stall request to Decode
- `stack_full`  out  1  shadow stack full
- `stack_empty`  out  1  shadow stack empty
- `err`  out  1  one-cycle pulse on protocol error

## Operation
- Commit: `wr = ex_valid & ex_cond_ex`. If `wr & ex_flags_write[1]`: N,Z <= ex_alu_flags[3:2]. If `wr & ex_flags_write[0]`: C,V <= ex_alu_flags[1:0]; saturated <= saturated | ex_alu_flags[4] (sticky).
- `sat_clear` forces saturated to 0; wins over a same-cycle sticky set. Other bits unaffected.
- Scoreboard counter `pend` (width clog2(PIPE_DEPTH+1)): +1 on `dec_issue & dec_sets_flags`; −1 on `ex_valid & |ex_flags_write` (independent of `ex_cond_ex`). Simultaneous inc/dec: unchanged.
- `flags_hazard = dec_reads_flags & (pend != 0)`.
- Increment at `pend == PIPE_DEPTH`: saturate, pulse `err`. Decrement at 0: hold 0, pulse `err`.
- `flush`: `pend` <= 0 next edge, overriding same-cycle inc/dec; flag commit in that cycle still applies.
- Priority on flag register: reset > restore > Execute commit > sat_clear mask.

## Timing
- Reset values: `flags`=5'b00000, `pend`=0, stack pointer=0, `flags_hazard` follows inputs (0 when `dec_reads_flags`=0), `stack_empty`=1, `stack_full`=0, `err`=0.
- Commit latency 1 cycle: flags written at edge N visible on `flags` after edge N; Decode instruction reading flags in cycle N+1 sees them.
- Hazard clears in the cycle after the last pending writer commits (counter registered).
- `err` asserted for exactly one cycle per offending event.
- Reset asserted mid-operation clears all state immediately, regardless of clock.

## Configuration
- `FLAGS_SHADOW_STACK_EN` defined: STACK_DEPTH-entry LIFO. `save_req` pushes pre-commit value of `flags` (value before this edge's commit); `restore_req` pops top into `flags`, discarding a same-cycle Execute commit. Push when full or pop when empty: ignored, `err` pulse. `save_req & restore_req` together: both ignored, `err` pulse.
- Not defined: no stack storage; `save_req`/`restore_req` ignored, `stack_full`=0, `stack_empty`=1, no `err` from them.

## Test plan
- Reset, then commit `ex_flags_write`=2'b11, `ex_cond_ex`=1, `ex_alu_flags`=5'b01010 -> `flags`=5'b01010 next cycle; repeat with `ex_cond_ex`=0 -> unchanged.
- Saturated sticky: commit alu 5'b10000 with write[0], then alu 5'b00000 -> `flags[4]`=1; assert `sat_clear` with simultaneous set -> `flags[4]`=0.
- Hazard: issue flag-setter, next cycle `dec_reads_flags`=1 -> `flags_hazard`=1 until cycle after Execute commit, then 0; issue 4 setters with PIPE_DEPTH=3 -> `pend`=3, `err` one pulse.
- Flush with `pend`=2 and simultaneous issue -> `pend`=0, `flags_hazard`=0 next cycle.
- Stack build: push 5'b00101, 5'b11000; pop twice -> `flags`=5'b11000 then 5'b00101, `stack_empty`=1; extra pop -> `err` pulse, flags held.
- Async reset asserted mid-cycle with `pend`=2, flags=5'b11111 -> all outputs at reset values before next edge.

Source files
------------

// File: rtl/flags_unit.sv
// Architectural flag register {saturated, N, Z, C, V} with in-flight writer scoreboard and Decode stall.
// Define FLAGS_SHADOW_STACK_EN to add the LIFO shadow stack used for flag save/restore on exceptions.
module flags_unit #(
    parameter int ALU_FLAGS_WIDTH = 5,
    parameter int PIPE_DEPTH      = 3,
    parameter int STACK_DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ex_valid,
    input  logic [1:0]                 ex_flags_write,
    input  logic                       ex_cond_ex,
    input  logic [ALU_FLAGS_WIDTH-1:0] ex_alu_flags,
    input  logic                       dec_issue,
    input  logic                       dec_sets_flags,
    input  logic                       dec_reads_flags,
    input  logic                       flush,
    input  logic                       sat_clear,
    input  logic                       save_req,
    input  logic                       restore_req,
    output logic [ALU_FLAGS_WIDTH-1:0] flags,
    output logic                       flags_hazard,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       err
);

    localparam int PW = $clog2(PIPE_DEPTH + 1);

    logic [PW-1:0]              pend;
    logic [PW-1:0]              pend_nx;
    logic [ALU_FLAGS_WIDTH-1:0] commit_flags;
    logic [ALU_FLAGS_WIDTH-1:0] flags_nx;
    logic                       wr;
    logic                       inc;
    logic                       dec;
    logic                       pend_err;
    logic                       stack_err;

    assign wr  = ex_valid & ex_cond_ex;
    assign inc = dec_issue & dec_sets_flags;
    // A writer leaves the pipe whether or not its condition passed
    assign dec = ex_valid & (|ex_flags_write);

    assign flags_hazard = dec_reads_flags & (pend != '0);

    always_comb begin
        pend_nx  = pend;
        pend_err = 1'b0;
        if (flush) begin
            pend_nx = '0;
        end else if (inc && !dec) begin
            if (pend == PW'(PIPE_DEPTH)) pend_err = 1'b1;
            else                         pend_nx  = pend + 1'b1;
        end else if (dec && !inc) begin
            if (pend == '0) pend_err = 1'b1;
            else            pend_nx  = pend - 1'b1;
        end
    end

    always_comb begin
        commit_flags = flags;
        if (wr && ex_flags_write[1]) begin
            commit_flags[3:2] = ex_alu_flags[3:2];
        end
        if (wr && ex_flags_write[0]) begin
            commit_flags[1:0] = ex_alu_flags[1:0];
            commit_flags[4]   = flags[4] | ex_alu_flags[4];
        end
        if (sat_clear) begin
            commit_flags[4] = 1'b0;
        end
    end

`ifdef FLAGS_SHADOW_STACK_EN
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ALU_FLAGS_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [SPW-1:0]             sp;
    logic                       push_ok;
    logic                       pop_ok;

    assign stack_full  = (sp == SPW'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign push_ok     = save_req & ~restore_req & ~stack_full;
    assign pop_ok      = restore_req & ~save_req & ~stack_empty;
    assign stack_err   = (save_req & restore_req)
                       | (save_req & ~restore_req & stack_full)
                       | (restore_req & ~save_req & stack_empty);

    // A restore replaces the whole word, dropping any same-cycle commit
    assign flags_nx = pop_ok ? stack_mem[SIW'(sp - 1'b1)] : commit_flags;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (push_ok) begin
            sp <= sp + 1'b1;
        end else if (pop_ok) begin
            sp <= sp - 1'b1;
        end
    end

    // Saved value is the pre-commit flag word
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack_mem[SIW'(sp)] <= flags;
        end
    end
`else
    logic unused_stack;

    assign unused_stack = save_req ^ restore_req ^ (STACK_DEPTH > 0);
    assign stack_full   = 1'b0;
    assign stack_empty  = 1'b1;
    assign stack_err    = 1'b0;
    assign flags_nx     = commit_flags;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= '0;
            pend  <= '0;
            err   <= 1'b0;
        end else begin
            flags <= flags_nx;
            pend  <= pend_nx;
            err   <= pend_err | stack_err;
        end
    end

endmodule
